// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and fetch-FSM encodings for the 16-bit
//                pipelined CPU.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Instruction encodings with fixed meaning in the front end
    localparam logic [15:0] NOP_INSTR  = 16'h0000;
    localparam logic [15:0] HALT_INSTR = 16'hFFFF;

    // Default PC / instruction-address width
    localparam int PC_W_DEF = 16;

    // Fetch FSM state encoding
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_RUN  = 2'd0;
    localparam fetch_state_t ST_HOLD = 2'd1;
    localparam fetch_state_t ST_HALT = 2'd2;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/fetch_ifid.sv
// ============================================================================
//  Module      : fetch_ifid
//  Description : Instruction-fetch stage and IF/ID pipeline register. Owns
//                the PC, issues single-outstanding imem requests, buffers a
//                response that arrives during a stall, and squashes on EX
//                redirects. Stops fetching on the halt encoding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ifid #(
    parameter int                 PC_W       = cpu_pkg::PC_W_DEF,
    parameter logic [PC_W-1:0]    RESET_PC   = '0,
    parameter logic [15:0]        HALT_INSTR = cpu_pkg::HALT_INSTR
) (
    input  logic            clk,
    input  logic            reset,       // asynchronous, active-low
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirectPC,
    output logic            imemReq,
    output logic [PC_W-1:0] imemAddr,
    input  logic            imemAck,
    input  logic [15:0]     imemRdata,
    output logic [15:0]     ifidInstr,
    output logic [PC_W-1:0] ifidPC,
    output logic            ifidValid,
    output logic            halted
);

    import cpu_pkg::*;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_hold;
    logic            r_hold_valid;
    logic [15:0]     r_ifid_instr;
    logic [PC_W-1:0] r_ifid_pc;
    logic            r_ifid_valid;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [PC_W-1:0] w_pc_inc;
    logic            w_in_run;
    logic            w_in_hold;
    logic            w_in_halt;
    logic            w_load;        // an instruction enters IF/ID this edge
    logic [15:0]     w_load_instr;  // which instruction that is
    logic            w_capture;     // ack arrives while stalled: park it

    assign w_pc_inc  = r_pc + PC_W'(2);   // wraps naturally at the top
    assign w_in_run  = (r_state == ST_RUN);
    assign w_in_hold = (r_state == ST_HOLD);
    assign w_in_halt = (r_state == ST_HALT);

    // Loads only happen on unstalled, non-redirect edges; HOLD drains the
    // parked word, RUN takes the live response.
    assign w_load       = !redirect && !stall &&
                          ((w_in_run && imemAck) || (w_in_hold && r_hold_valid));
    assign w_load_instr = w_in_hold ? r_hold : imemRdata;
    assign w_capture    = !redirect && stall && w_in_run && imemAck;

    // Requests only go out in RUN; reset low suppresses them immediately.
    assign imemReq   = w_in_run && reset;
    assign imemAddr  = r_pc;
    assign ifidInstr = r_ifid_instr;
    assign ifidPC    = r_ifid_pc;
    assign ifidValid = r_ifid_valid;
    assign halted    = w_in_halt;

    // PC, FSM, hold buffer and IF/ID register; priority reset > redirect > stall > ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_hold       <= NOP_INSTR;
            r_hold_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (redirect) begin
            // Squash everything in flight, including a same-cycle ack
            r_state      <= ST_RUN;
            r_pc         <= redirectPC;
            r_hold_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (!stall) begin
            if (w_load) begin
                r_ifid_instr <= w_load_instr;
                r_ifid_pc    <= r_pc;
                r_ifid_valid <= 1'b1;
                r_pc         <= w_pc_inc;
                r_hold_valid <= 1'b0;
                r_state      <= (w_load_instr == HALT_INSTR) ? ST_HALT : ST_RUN;
            end else begin
                // RUN waiting on memory, or HALT: present a bubble
                r_ifid_instr <= NOP_INSTR;
                r_ifid_pc    <= '0;
                r_ifid_valid <= 1'b0;
            end
        end else if (w_capture) begin
            // IF/ID is frozen; keep the response until the stall clears
            r_hold       <= imemRdata;
            r_hold_valid <= 1'b1;
            r_state      <= ST_HOLD;
        end
    end

endmodule : fetch_ifid

`default_nettype wire

// File: tb/tb_fetch_ifid.sv
// ============================================================================
//  Module      : tb_fetch_ifid
//  Description : Scoreboard testbench for fetch_ifid. Directed per-cycle
//                vectors push hand-computed post-edge expectations; a monitor
//                pops and compares after each rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ifid;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemAck;
    logic [15:0] imemRdata;
    logic [15:0] ifidInstr;
    logic [15:0] ifidPC;
    logic        ifidValid;
    logic        halted;

    fetch_ifid dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPC (redirectPC),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemRdata  (imemRdata),
        .ifidInstr  (ifidInstr),
        .ifidPC     (ifidPC),
        .ifidValid  (ifidValid),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        valid;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        req;
        logic [15:0] addr;
        logic        hlt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void chk(string name, int id, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endfunction

    // Monitor: compare the DUT against the oldest pending expectation
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ifidValid", e.id, {15'd0, ifidValid}, {15'd0, e.valid});
            chk("ifidInstr", e.id, ifidInstr, e.instr);
            if (e.valid)
                chk("ifidPC", e.id, ifidPC, e.pc);
            chk("imemReq", e.id, {15'd0, imemReq}, {15'd0, e.req});
            chk("imemAddr", e.id, imemAddr, e.addr);
            chk("halted", e.id, {15'd0, halted}, {15'd0, e.hlt});
        end
    end

    int step_id = 0;

    // Drive one cycle of inputs and queue the state expected after the edge
    task automatic step(input logic st, input logic rd, input logic [15:0] rpc,
                        input logic ack, input logic [15:0] rdata,
                        input logic ev, input logic [15:0] ei, input logic [15:0] ep,
                        input logic ereq, input logic [15:0] eaddr, input logic eh);
        exp_t e;
        @(negedge clk);
        stall      = st;
        redirect   = rd;
        redirectPC = rpc;
        imemAck    = ack;
        imemRdata  = rdata;
        step_id++;
        e.id = step_id; e.valid = ev; e.instr = ei; e.pc = ep;
        e.req = ereq; e.addr = eaddr; e.hlt = eh;
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input int id);
        chk("rst_ifidValid", id, {15'd0, ifidValid}, 16'd0);
        chk("rst_ifidInstr", id, ifidInstr, 16'h0000);
        chk("rst_ifidPC",    id, ifidPC, 16'h0000);
        chk("rst_imemReq",   id, {15'd0, imemReq}, 16'd0);
        chk("rst_imemAddr",  id, imemAddr, 16'h0000);
        chk("rst_halted",    id, {15'd0, halted}, 16'd0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPC = 16'h0;
        imemAck = 1'b0; imemRdata = 16'h0;
        #3;
        check_reset_outputs(0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("req_after_release", 0, {15'd0, imemReq}, 16'd1);

        //     st rd rpc      ack data      ev ei       ep       req addr     h
        // Zero-wait fetch
        step(0, 0, 16'h0000, 1, 16'h1000, 1, 16'h1000, 16'h0000, 1, 16'h0002, 0);
        step(0, 0, 16'h0000, 1, 16'h1002, 1, 16'h1002, 16'h0002, 1, 16'h0004, 0);
        step(0, 0, 16'h0000, 1, 16'h1004, 1, 16'h1004, 16'h0004, 1, 16'h0006, 0);
        // Stall with ack of A111 at PC 6: IF/ID frozen, HOLD suppresses req
        step(1, 0, 16'h0000, 1, 16'hA111, 1, 16'h1004, 16'h0004, 0, 16'h0006, 0);
        step(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h1004, 16'h0004, 0, 16'h0006, 0);
        step(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h1004, 16'h0004, 0, 16'h0006, 0);
        step(0, 0, 16'h0000, 0, 16'h0000, 1, 16'hA111, 16'h0006, 1, 16'h0008, 0);
        // Two wait states then ack: two bubbles, pc held
        step(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0008, 0);
        step(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0008, 0);
        step(0, 0, 16'h0000, 1, 16'h1008, 1, 16'h1008, 16'h0008, 1, 16'h000A, 0);
        // Redirect during stall with same-cycle ack: ack discarded, flush
        step(1, 1, 16'h0040, 1, 16'h1234, 0, 16'h0000, 16'h0000, 1, 16'h0040, 0);
        step(0, 0, 16'h0000, 1, 16'h1040, 1, 16'h1040, 16'h0040, 1, 16'h0042, 0);
        // Halt at PC 8
        step(0, 1, 16'h0008, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0008, 0);
        step(0, 0, 16'h0000, 1, 16'hFFFF, 1, 16'hFFFF, 16'h0008, 0, 16'h000A, 1);
        step(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h000A, 1);
        step(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h000A, 1);
        // Redirect out of HALT resumes fetch
        step(0, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0);
        step(0, 0, 16'h0000, 1, 16'h1000, 1, 16'h1000, 16'h0000, 1, 16'h0002, 0);
        // PC wrap FFFE -> 0000
        step(0, 1, 16'hFFFE, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'hFFFE, 0);
        step(0, 0, 16'h0000, 1, 16'h0FFE, 1, 16'h0FFE, 16'hFFFE, 1, 16'h0000, 0);
        step(0, 0, 16'h0000, 1, 16'h1000, 1, 16'h1000, 16'h0000, 1, 16'h0002, 0);
        // Enter HOLD, then reset asynchronously mid-cycle
        step(1, 0, 16'h0000, 1, 16'hB222, 1, 16'h1000, 16'h0000, 0, 16'h0002, 0);

        @(negedge clk);
        stall = 1'b1; imemAck = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs(99);
        @(negedge clk);
        reset = 1'b1; stall = 1'b0;
        // Parked B222 must be gone: fetch restarts at RESET_PC
        step(0, 0, 16'h0000, 1, 16'h1000, 1, 16'h1000, 16'h0000, 1, 16'h0002, 0);
        step(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0);

        begin
            int budget;
            budget = 0;
            while (q.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            #2;
            if (q.size() > 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL drain: %0d entries left, required 0", q.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_ifid

`default_nettype wire

// File: doc/fetch_ifid.md
# fetch_ifid

Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined CPU. Sits directly upstream of the ID stage: it owns the PC, drives a single-outstanding instruction-memory request, and presents fetched instructions to decode. Decode results then enter the ID/EX register. It obeys the same hazard-unit `stall` as ID/EX and squashes its contents on a taken branch or jump redirect from EX.

## Interface
- `PC_W`, 16: PC and instruction-address width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `HALT_INSTR`, 16'hFFFF: encoding that stops fetch.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low.
- `stall`  in  1  from the hazard unit; holds PC and the IF/ID register.
- `redirect`  in  1  taken branch or jump resolved in EX.
- `redirectPC`  in  PC_W  target address; valid when `redirect`=1.
- `imemReq`  out  1  fetch request.
- `imemAddr`  out  PC_W  fetch address (current PC).
- `imemAck`  in  1  `imemRdata` valid this cycle; 0 or more wait cycles after the request.
- `imemRdata`  in  16  fetched instruction.
- `ifidInstr`  out  16  instruction to decode; 16'h0000 (NOP) when invalid.
- `ifidPC`  out  PC_W  byte address of `ifidInstr`.
- `ifidValid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch stopped on `HALT_INSTR`.

## Operation
- Internal state: `pc`, a 16-bit hold buffer with a `holdValid` flag, and an FSM with states RUN, HOLD, HALT.
- `imemReq` = 1 in RUN when `reset`=1; 0 in HOLD, in HALT, and while `reset`=0. `imemAddr` = `pc` at all times.
- `pc` increments by 2 per accepted instruction; wraps 16'hFFFE -> 16'h0000 with no flag.
- Per-edge priority: reset > redirect > stall > ack.
- **Redirect (any state):**
  - `pc`<=`redirectPC`; IF/ID flushed (`ifidValid`=0, `ifidInstr`=0, `ifidPC`=0).
  - `holdValid`<=0; an `imemAck` in the same cycle is discarded.
  - State <= RUN.
  - Redirect overrides `stall`.
- **RUN:**
  - `imemAck`=1 and `stall`=0: IF/ID <= {`imemRdata`, `pc`, valid=1}; `pc`<=`pc`+2.
  - `imemAck`=1 and `stall`=1: hold buffer <= `imemRdata`; `holdValid`<=1; `pc` unchanged; IF/ID unchanged; -> HOLD.
  - `imemAck`=0 and `stall`=0: IF/ID becomes a bubble (`ifidValid`=0, `ifidInstr`=0).
  - `imemAck`=0 and `stall`=1: IF/ID unchanged.
- **HOLD:**
  - Stays in HOLD while `stall`=1.
  - On the first cycle with `stall`=0: IF/ID <= {hold buffer, `pc`, 1}; `pc`<=`pc`+2; `holdValid`<=0; -> RUN.
- **Halt detection:** when `HALT_INSTR` is loaded into IF/ID (from RUN or HOLD), state -> HALT.
  - The halt instruction itself is valid in IF/ID for that cycle.
- **HALT:**
  - `halted`=1; no requests are issued.
  - The next non-stalled edge inserts a bubble into IF/ID.
  - Only `redirect` or reset leaves HALT.
- **Reset (async, `reset`=0):**
  - `pc`=`RESET_PC`; state RUN; `holdValid`=0.
  - `ifidInstr`=0, `ifidPC`=0, `ifidValid`=0, `halted`=0.
  - Takes effect immediately, mid-fetch or mid-stall; the outstanding response is lost.

## Timing
- **Latency:** an ack at edge N makes the instruction visible on the IF/ID outputs after edge N. A zero-wait memory sustains 1 instruction per cycle.
- **Stall:** IF/ID is frozen on every edge with `stall`=1. This matches ID/EX freeze behaviour, so the two registers stay aligned.
- **Single outstanding fetch:** the request for `pc`+2 begins the cycle after acceptance.
- **Redirect:** the first request to `redirectPC` is issued in the cycle after the redirect edge. IF/ID shows a bubble for at least 1 cycle.
- **Reset release:** the first request is issued in the first cycle with `reset`=1.

## Structure
- Shared package `cpu_pkg` holds:
  - `NOP_INSTR` = 16'h0000 and `HALT_INSTR` = 16'hFFFF.
  - The `PC_W` default.
  - The fetch FSM state enum (RUN, HOLD, HALT).
- Single module.
- The PC incrementer and mux stay inline; no sub-module is warranted.

## Test plan
- **Reset then zero-wait fetch:** with imem returning 16'h1000+addr and ack every cycle, IF/ID shows PC 0,2,4 with `ifidValid`=1 on consecutive cycles; `ifidPC` matches the address.
- **Wait states:** with ack every 3rd cycle, exactly 2 bubble cycles appear between instructions; `pc` is unchanged during the wait.
- **Stall with ack:** assert `stall` for 3 cycles coinciding with an ack of 16'hA111 at PC 6. IF/ID holds its old value, `imemReq`=0 in HOLD, and 16'hA111/PC 6 appears the cycle after `stall` drops.
- **Redirect during stall:** with `stall`=1, `redirect`=1, `redirectPC`=16'h0040 and a same-cycle ack, the ack is discarded and IF/ID is flushed to 0. The next `imemAddr` is 16'h0040, and the first instruction is at `ifidPC` 16'h0040.
- **Halt:** fetching 16'hFFFF at PC 8 makes it valid once, then `halted`=1 and `imemReq`=0 with bubbles after. A redirect to 16'h0000 resumes fetch.
- **Async reset mid-HOLD, plus wrap:** reset mid-HOLD clears all outputs immediately. Separately, `pc` 16'hFFFE advances to 16'h0000.
